// File: rtl/pll0_ctrl.sv
// Power-up / relock sequencer for the core0 PLL, clocked by the PLL reference.
// Handles reset timing, lock qualification, retries and bypass-protected divider changes.
module pll0_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned BPS_SETTLE   = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [1:0]  DEFAULT_DIV  = 2'b11
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pll_locked_i,
  input  logic [1:0] div_req_i,
  input  logic       div_req_valid_i,
  output logic       div_req_ready_o,
  input  logic       force_bps_i,
  output logic       pll_rstn_o,
  output logic [1:0] pll_div_o,
  output logic       pll_bps_o,
  output logic       clk_ready_o,
  output logic       fail_o,
  output logic       lock_lost_o,
  output logic [1:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int unsigned MaxA   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxB   = (LOCK_STABLE > BPS_SETTLE) ? LOCK_STABLE : BPS_SETTLE;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  // The WAIT cycle that first saw lock counts as the first cycle of the window.
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 2);
  localparam logic [CntW-1:0] SettleLast  = CntW'(BPS_SETTLE - 1);
  localparam logic [1:0]      RetryMax    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    StHold   = 3'd0,
    StWait   = 3'd1,
    StStable = 3'd2,
    StRun    = 3'd3,
    StSwitch = 3'd4,
    StFail   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic [1:0]      div_q, div_d;
  logic [1:0]      div_lat_q, div_lat_d;
  logic            rstn_q, rstn_d;
  logic            bps_q, bps_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            lost_q, lost_d;
  logic            lock_meta_q, lock_s_q;
  logic            req_fire;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign div_req_ready_o = (state_q == StRun && lock_s_q) || (state_q == StFail);
  assign req_fire        = div_req_valid_i && div_req_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_q;
    div_d     = div_q;
    div_lat_d = div_lat_q;
    lost_d    = 1'b0;

    unique case (state_q)
      StHold: begin
        if (cnt_q == RstLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (lock_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          retry_d = retry_q + 2'd1;
          cnt_d   = '0;
          state_d = (retry_d == RetryMax) ? StFail : StHold;
        end
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          state_d = StHold;
          lost_d  = 1'b1;
        end else if (req_fire) begin
          state_d   = StSwitch;
          div_lat_d = div_req_i;
        end
      end
      StSwitch: begin
        if (cnt_q == SettleLast) begin
          state_d = StHold;
          cnt_d   = '0;
          div_d   = div_lat_q;
        end
      end
      StFail: begin
        cnt_d = '0;
        if (req_fire) begin
          state_d = StHold;
          div_d   = div_req_i;
          retry_d = '0;
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase

    // Registered outputs follow the state being entered.
    rstn_d  = (state_d == StWait) || (state_d == StStable) ||
              (state_d == StRun) || (state_d == StSwitch);
    ready_d = (state_d == StRun) || (state_d == StFail);
    fail_d  = (state_d == StFail);
    bps_d   = (state_d == StRun) ? force_bps_i : 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      retry_q   <= '0;
      div_q     <= DEFAULT_DIV;
      div_lat_q <= DEFAULT_DIV;
      rstn_q    <= 1'b0;
      bps_q     <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      rstn_q    <= rstn_d;
      bps_q     <= bps_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
    end
  end

  assign pll_rstn_o  = rstn_q;
  assign pll_div_o   = div_q;
  assign pll_bps_o   = bps_q;
  assign clk_ready_o = ready_q;
  assign fail_o      = fail_q;
  assign lock_lost_o = lost_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll0_ctrl.sv
// Directed bench for pll0_ctrl: power-up, lock qualification, retries/FAIL,
// divider switch, lock loss, bypass forcing and asynchronous reset.
module tb_pll0_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pll_locked;
  logic [1:0] div_req;
  logic       div_req_valid;
  logic       div_req_ready;
  logic       force_bps;
  logic       pll_rstn;
  logic [1:0] pll_div;
  logic       pll_bps;
  logic       clk_ready;
  logic       fail;
  logic       lock_lost;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  pll0_ctrl dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .pll_locked_i    (pll_locked),
    .div_req_i       (div_req),
    .div_req_valid_i (div_req_valid),
    .div_req_ready_o (div_req_ready),
    .force_bps_i     (force_bps),
    .pll_rstn_o      (pll_rstn),
    .pll_div_o       (pll_div),
    .pll_bps_o       (pll_bps),
    .clk_ready_o     (clk_ready),
    .fail_o          (fail),
    .lock_lost_o     (lock_lost),
    .retry_cnt_o     (retry_cnt),
    .state_o         (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, output int cnt);
    cnt = 0;
    while (state !== st && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_rstn_high(input int limit, output int cnt);
    cnt = 0;
    while (pll_rstn !== 1'b1 && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"}, 32'(state), 0);
    check({pfx, "_pll_rstn"}, 32'(pll_rstn), 0);
    check({pfx, "_div"}, 32'(pll_div), 3);
    check({pfx, "_bps"}, 32'(pll_bps), 1);
    check({pfx, "_clk_ready"}, 32'(clk_ready), 0);
    check({pfx, "_fail"}, 32'(fail), 0);
    check({pfx, "_lock_lost"}, 32'(lock_lost), 0);
    check({pfx, "_retry"}, 32'(retry_cnt), 0);
  endtask

  initial begin
    rstn          = 1'b0;
    pll_locked    = 1'b0;
    div_req       = 2'b00;
    div_req_valid = 1'b0;
    force_bps     = 1'b0;
    step(2);
    check_reset_values("rst");
    check("rst_req_ready", 32'(div_req_ready), 0);

    // Power-up: 16 reset cycles, lock 100 cycles later, RUN 2+64 cycles after lock.
    rstn = 1'b1;
    wait_rstn_high(100, n);
    check("hold_len", n, 16);
    check("wait_entry_state", 32'(state), 1);
    step(100);
    pll_locked = 1'b1;
    wait_state(3'd3, 200, n);
    check("lock_to_run", n, 66);
    check("run_clk_ready", 32'(clk_ready), 1);
    check("run_div", 32'(pll_div), 3);
    check("run_bps", 32'(pll_bps), 0);
    check("run_pll_rstn", 32'(pll_rstn), 1);
    check("run_req_ready", 32'(div_req_ready), 1);

    // force_bps follows one cycle later.
    force_bps = 1'b1;
    check("fbps_not_yet", 32'(pll_bps), 0);
    step(1);
    check("fbps_on", 32'(pll_bps), 1);
    force_bps = 1'b0;
    step(1);
    check("fbps_off", 32'(pll_bps), 0);

    // Divider change to 01.
    div_req       = 2'b01;
    div_req_valid = 1'b1;
    check("sw_req_ready", 32'(div_req_ready), 1);
    step(1);
    div_req_valid = 1'b0;
    div_req       = 2'b00;
    check("sw_state", 32'(state), 4);
    check("sw_clk_ready", 32'(clk_ready), 0);
    check("sw_bps", 32'(pll_bps), 1);
    check("sw_div_held", 32'(pll_div), 3);
    check("sw_pll_rstn", 32'(pll_rstn), 1);
    n = 0;
    while (state === 3'd4 && n < 20) begin
      step(1);
      n++;
    end
    check("sw_len", n, 4);
    check("sw_hold_state", 32'(state), 0);
    check("sw_new_div", 32'(pll_div), 1);
    check("sw_rstn_fall", 32'(pll_rstn), 0);
    pll_locked = 1'b0;
    wait_rstn_high(100, n);
    check("sw_hold_len", n, 16);

    // Relock with a 1-cycle glitch during STABLE.
    step(10);
    pll_locked = 1'b1;
    wait_state(3'd2, 20, n);
    check("stable_entry", n, 3);
    step(10);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    check("glitch_to_wait", 32'(state), 1);
    wait_state(3'd3, 200, n);
    check("glitch_full_window", n, 64);
    check("relock_div", 32'(pll_div), 1);
    check("relock_clk_ready", 32'(clk_ready), 1);

    // Lock loss with a same-cycle request: loss wins, no handshake.
    pll_locked = 1'b0;
    step(2);
    div_req       = 2'b10;
    div_req_valid = 1'b1;
    check("loss_req_ready", 32'(div_req_ready), 0);
    check("loss_still_run", 32'(state), 3);
    step(1);
    check("loss_state", 32'(state), 0);
    check("loss_pulse", 32'(lock_lost), 1);
    check("loss_clk_ready", 32'(clk_ready), 0);
    check("loss_bps", 32'(pll_bps), 1);
    check("loss_div_kept", 32'(pll_div), 1);
    check("loss_pll_rstn", 32'(pll_rstn), 0);
    div_req_valid = 1'b0;
    div_req       = 2'b00;
    step(1);
    check("loss_pulse_end", 32'(lock_lost), 0);

    // Lock never asserts: three timeouts then FAIL.
    for (int a = 1; a <= 3; a++) begin
      wait_state(3'd1, 100, n);
      check("to_wait_entry", n, (a == 1) ? 15 : 16);
      n = 0;
      while (state === 3'd1 && n < 5000) begin
        step(1);
        n++;
      end
      check("to_wait_len", n, 4096);
      check("to_retry", 32'(retry_cnt), 32'(a));
      check("to_next_state", 32'(state), (a == 3) ? 5 : 0);
    end
    check("fail_flag", 32'(fail), 1);
    check("fail_bps", 32'(pll_bps), 1);
    check("fail_clk_ready", 32'(clk_ready), 1);
    check("fail_pll_rstn", 32'(pll_rstn), 0);
    check("fail_req_ready", 32'(div_req_ready), 1);

    // Request out of FAIL.
    div_req       = 2'b00;
    div_req_valid = 1'b1;
    step(1);
    div_req_valid = 1'b0;
    check("unfail_state", 32'(state), 0);
    check("unfail_div", 32'(pll_div), 0);
    check("unfail_flag", 32'(fail), 0);
    check("unfail_retry", 32'(retry_cnt), 0);
    check("unfail_clk_ready", 32'(clk_ready), 0);

    // Async reset in the middle of SWITCH.
    wait_rstn_high(100, n);
    step(5);
    pll_locked = 1'b1;
    wait_state(3'd3, 200, n);
    check("pre_ar_run", 32'(state), 3);
    div_req       = 2'b10;
    div_req_valid = 1'b1;
    step(1);
    div_req_valid = 1'b0;
    check("pre_ar_switch", 32'(state), 4);
    step(1);
    #2 rstn = 1'b0;
    #1 check_reset_values("arst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
